// File: rtl/clock_display_scanner.sv
// Scans four snapshotted BCD time digits onto a multiplexed 7-segment display.
// The display only takes new digits at frame boundaries. Each slot starts with one blank cycle.
module clock_display_scanner #(
  parameter int REFRESH_DIV    = 1000,
  parameter int BLINK_FRAMES   = 125,
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] hourst,
  input  logic [3:0] hoursu,
  input  logic [3:0] mint,
  input  logic [3:0] minu,
  input  logic       load,
  input  logic       blank_lead,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an,
  output logic       frame_done
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic [3:0] AN_OFF  = {4{SEG_ACTIVE_LOW}};
  localparam logic       DP_OFF  = SEG_ACTIVE_LOW;

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0: decode = 7'h3F;
      4'd1: decode = 7'h06;
      4'd2: decode = 7'h5B;
      4'd3: decode = 7'h4F;
      4'd4: decode = 7'h66;
      4'd5: decode = 7'h6D;
      4'd6: decode = 7'h7D;
      4'd7: decode = 7'h07;
      4'd8: decode = 7'h7F;
      4'd9: decode = 7'h6F;
      default: decode = 7'h40;
    endcase
  endfunction

  logic [PW-1:0]   presc_q, presc_d;
  logic [1:0]      slot_q, slot_d;
  logic [3:0][3:0] pend_q, pend_d;
  logic [3:0][3:0] disp_q, disp_d;
  logic [FW-1:0]   fcnt_q, fcnt_d;
  logic            colon_q, colon_d;
  logic [6:0]      seg_q, seg_d;
  logic [3:0]      an_q, an_d;
  logic            dp_q, dp_d;

  logic       term, fd, lead_off;
  logic [3:0] digit;

  always_comb begin
    term    = (presc_q == PW'(REFRESH_DIV - 1));
    fd      = term && (slot_q == 2'd3);
    presc_d = term ? '0 : presc_q + PW'(1);
    slot_d  = term ? slot_q + 2'd1 : slot_q;
    pend_d  = load ? {hourst, hoursu, mint, minu} : pend_q;
    disp_d  = fd ? pend_q : disp_q;
    fcnt_d  = fcnt_q;
    colon_d = colon_q;
    if (fd) begin
      if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
        fcnt_d  = '0;
        colon_d = ~colon_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end

    digit    = disp_q[slot_q];
    lead_off = blank_lead && (slot_q == 2'd3) && (digit == 4'd0);
    an_d     = AN_OFF;
    seg_d    = SEG_OFF;
    dp_d     = DP_OFF;
    // First cycle of a slot stays dark so the previous digit cannot ghost onto the next anode
    if (presc_q != '0 && !lead_off) begin
      an_d  = (4'b0001 << slot_q) ^ AN_OFF;
      seg_d = decode(digit) ^ SEG_OFF;
      dp_d  = ((slot_q == 2'd2) && colon_q) ^ DP_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      slot_q  <= '0;
      pend_q  <= '0;
      disp_q  <= '0;
      fcnt_q  <= '0;
      colon_q <= 1'b1;
      seg_q   <= SEG_OFF;
      an_q    <= AN_OFF;
      dp_q    <= DP_OFF;
    end else begin
      presc_q <= presc_d;
      slot_q  <= slot_d;
      pend_q  <= pend_d;
      disp_q  <= disp_d;
      fcnt_q  <= fcnt_d;
      colon_q <= colon_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
      dp_q    <= dp_d;
    end
  end

  assign seg        = seg_q;
  assign an         = an_q;
  assign dp         = dp_q;
  assign frame_done = fd;
endmodule

// File: tb/tb_clock_display_scanner.sv
// Directed bench: an active-high instance walks frame by frame, an active-low twin covers reset.
module tb_clock_display_scanner;
  logic       clk = 1'b0;
  logic       rst_n_a, rst_n_b;
  logic [3:0] hourst, hoursu, mint, minu;
  logic       load, blank_lead;
  logic [6:0] seg_a, seg_b;
  logic [3:0] an_a, an_b;
  logic       dp_a, dp_b, fd_a, fd_b;
  int         n_chk = 0, n_pass = 0, frame = 0;

  always #5 clk = ~clk;

  clock_display_scanner #(.REFRESH_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n_a), .hourst(hourst), .hoursu(hoursu), .mint(mint), .minu(minu),
    .load(load), .blank_lead(blank_lead), .seg(seg_a), .dp(dp_a), .an(an_a), .frame_done(fd_a));

  clock_display_scanner #(.REFRESH_DIV(4), .BLINK_FRAMES(2), .SEG_ACTIVE_LOW(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n_b), .hourst(hourst), .hoursu(hoursu), .mint(mint), .minu(minu),
    .load(load), .blank_lead(blank_lead), .seg(seg_b), .dp(dp_b), .an(an_b), .frame_done(fd_b));

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: seg_of = 7'h3F; 4'd1: seg_of = 7'h06; 4'd2: seg_of = 7'h5B; 4'd3: seg_of = 7'h4F;
      4'd4: seg_of = 7'h66; 4'd5: seg_of = 7'h6D; 4'd6: seg_of = 7'h7D; 4'd7: seg_of = 7'h07;
      4'd8: seg_of = 7'h7F; 4'd9: seg_of = 7'h6F; default: seg_of = 7'h40;
    endcase
  endfunction

  task automatic drive(input logic [15:0] v);
    {hourst, hoursu, mint, minu} = v;
    load = 1'b1;
  endtask

  // Called on the frame_done cycle; walks the next 16 cycles (one full frame of A).
  // Step n shows output registers computed from the state one cycle earlier.
  task automatic grab(input logic [15:0] ed, input logic edp, input logic bl,
                      input int l1s, input logic [15:0] l1v, input int l2s, input logic [15:0] l2v);
    int fdc = 0;
    logic [3:0] dig;
    logic off;
    blank_lead = bl;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      if (fd_a) fdc++;
      for (int s = 0; s < 4; s++) begin
        if (n == 4*s + 2)
          chk($sformatf("f%0d_s%0d_blank", frame, s), 16'({an_a, seg_a, dp_a}), 16'h0);
        if (n == 4*s + 4) begin
          dig = ed[4*s +: 4];
          off = bl && (s == 3) && (dig == 4'd0);
          chk($sformatf("f%0d_s%0d_an", frame, s), 16'(an_a), off ? 16'h0 : 16'(4'b0001 << s));
          chk($sformatf("f%0d_s%0d_seg", frame, s), 16'(seg_a), off ? 16'h0 : 16'(seg_of(dig)));
          chk($sformatf("f%0d_s%0d_dp", frame, s), 16'(dp_a), 16'((s == 2) && edp));
        end
      end
      load = 1'b0;
      if (n == l1s) drive(l1v);
      else if (n == l2s) drive(l2v);
    end
    chk($sformatf("f%0d_fd_count", frame), 16'(fdc), 16'd1);
    chk($sformatf("f%0d_fd_last", frame), 16'(fd_a), 16'd1);
    frame++;
  endtask

  initial begin
    int wait_cnt;
    rst_n_a = 1'b0; rst_n_b = 1'b0; load = 1'b0; blank_lead = 1'b0;
    {hourst, hoursu, mint, minu} = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_a", 16'({seg_a, an_a, dp_a, fd_a}), 16'h0);
    chk("rst_b", 16'({seg_b, an_b, dp_b}), 16'h0FFF);
    rst_n_a = 1'b1; rst_n_b = 1'b1;
    drive(16'h1234);
    @(negedge clk);
    load = 1'b0;
    wait_cnt = 0;
    while (!fd_a && wait_cnt < 40) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("first_fd", 16'(fd_a), 16'd1);
    frame = 1;
    grab(16'h1234, 1'b1, 1'b0, 3, 16'h0759, 0, 16'h0);
    grab(16'h0759, 1'b0, 1'b1, 7, 16'h1111, 11, 16'h2222);
    grab(16'h2222, 1'b0, 1'b1, 16, 16'h0759, 0, 16'h0);
    grab(16'h2222, 1'b1, 1'b0, 0, 16'h0, 0, 16'h0);
    grab(16'h0759, 1'b1, 1'b0, 5, 16'h1FAC, 0, 16'h0);
    grab(16'h1FAC, 1'b0, 1'b0, 0, 16'h0, 0, 16'h0);

    // B tracks A in phase; step into slot 2 of frame 7 and reset B there
    repeat (11) @(negedge clk);
    chk("b_slot2_an", 16'(an_b), 16'h000B);
    chk("b_slot2_seg", 16'(seg_b), 16'h003F);
    rst_n_b = 1'b0;
    #1;
    chk("b_async_rst", 16'({seg_b, an_b, dp_b}), 16'h0FFF);
    repeat (2) @(negedge clk);
    chk("b_held_rst", 16'({seg_b, an_b, dp_b}), 16'h0FFF);
    rst_n_b = 1'b1;
    for (int m = 1; m <= 10; m++) begin
      @(negedge clk);
      if (m == 1) chk("b_restart_blank", 16'({seg_b, an_b, dp_b}), 16'h0FFF);
      if (m == 2) chk("b_restart_s0", 16'({seg_b, an_b, dp_b}), 16'({7'h40, 4'hE, 1'b1}));
      if (m == 6) chk("b_restart_s1", 16'({seg_b, an_b, dp_b}), 16'({7'h40, 4'hD, 1'b1}));
      if (m == 10) chk("b_restart_s2", 16'({seg_b, an_b, dp_b}), 16'({7'h40, 4'hB, 1'b0}));
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
endmodule
